// File: rtl/step_judge_pkg.sv
// rtl/step_judge_pkg.sv - shared lane count, grade/state enums and popcount helper for step_judge
package step_judge_pkg;

  localparam int NUM_LANES = 4;

  typedef enum logic [2:0] {
    GR_NONE,
    GR_PERFECT,
    GR_GOOD,
    GR_MISS,
    GR_BOO
  } grade_e;

  typedef enum logic {
    LANE_IDLE,
    LANE_ARMED
  } lane_state_e;

  function automatic logic [2:0] popcount4(input logic [NUM_LANES-1:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/step_judge_if.sv
// rtl/step_judge_if.sv - chart/button inputs and grade/combo outputs of step_judge
// score_o exists only when STEP_JUDGE_SCORE_EN is defined.
interface step_judge_if;
  import step_judge_pkg::*;

  logic                 sixteenth_i;
  logic [NUM_LANES-1:0] note_i;
  logic [NUM_LANES-1:0] buttons_i;
  logic [NUM_LANES-1:0] perfect_o;
  logic [NUM_LANES-1:0] good_o;
  logic [NUM_LANES-1:0] miss_o;
  logic [NUM_LANES-1:0] boo_o;
  logic [15:0]          combo_o;
`ifdef STEP_JUDGE_SCORE_EN
  logic [23:0]          score_o;
`endif

  modport master (
    output sixteenth_i, note_i, buttons_i,
    input  perfect_o, good_o, miss_o, boo_o, combo_o
`ifdef STEP_JUDGE_SCORE_EN
    , input score_o
`endif
  );

  modport slave (
    input  sixteenth_i, note_i, buttons_i,
    output perfect_o, good_o, miss_o, boo_o, combo_o
`ifdef STEP_JUDGE_SCORE_EN
    , output score_o
`endif
  );

endinterface

// File: rtl/step_judge_lane.sv
// rtl/step_judge_lane.sv - one lane: IDLE/ARMED FSM with window counter, grades each cycle combinationally
module step_judge_lane
  import step_judge_pkg::*;
#(
  parameter int WINDOW_PERFECT = 26250,
  parameter int WINDOW_GOOD    = 52500
) (
  input  logic   clk_i,
  input  logic   reset_i,
  input  logic   arm_i,
  input  logic   rise_i,
  output grade_e grade_o
);

  localparam int CW = $clog2(WINDOW_GOOD + 1);
  localparam logic [CW-1:0] PERFECT_LIM = CW'(WINDOW_PERFECT);
  localparam logic [CW-1:0] LAST_CNT    = CW'(WINDOW_GOOD - 1);

  lane_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= LANE_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grade_o = GR_NONE;
    case (state_q)
      LANE_IDLE: begin
        if (arm_i) begin
          // A press coinciding with the arming strobe is the best possible hit.
          if (rise_i) begin
            grade_o = GR_PERFECT;
          end else begin
            state_d = LANE_ARMED;
            cnt_d   = '0;
          end
        end else if (rise_i) begin
          grade_o = GR_BOO;
        end
      end
      LANE_ARMED: begin
        // The pending note is always judged before any re-arm takes effect.
        if (rise_i) begin
          grade_o = (cnt_q < PERFECT_LIM) ? GR_PERFECT : GR_GOOD;
        end else if (arm_i || cnt_q == LAST_CNT) begin
          grade_o = GR_MISS;
        end
        if (arm_i) begin
          cnt_d = '0;
        end else if (rise_i || cnt_q == LAST_CNT) begin
          state_d = LANE_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = LANE_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/step_judge.sv
// rtl/step_judge.sv - per-lane step grading with registered pulses, combo and optional score (STEP_JUDGE_SCORE_EN)
module step_judge
  import step_judge_pkg::*;
#(
  parameter int WINDOW_PERFECT = 26250,
  parameter int WINDOW_GOOD    = 52500
) (
  input logic         clk_i,
  input logic         reset_i,
  step_judge_if.slave bus
);

  logic [NUM_LANES-1:0] btn_q;
  logic [NUM_LANES-1:0] rise, arm;
  grade_e               lane_grade [NUM_LANES];

  logic [NUM_LANES-1:0] perfect_q, perfect_d;
  logic [NUM_LANES-1:0] good_q, good_d;
  logic [NUM_LANES-1:0] miss_q, miss_d;
  logic [NUM_LANES-1:0] boo_q, boo_d;
  logic [15:0]          combo_q, combo_d;
  logic [16:0]          combo_sum;

  assign rise = bus.buttons_i & ~btn_q;
  assign arm  = {NUM_LANES{bus.sixteenth_i}} & bus.note_i;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    step_judge_lane #(
      .WINDOW_PERFECT(WINDOW_PERFECT),
      .WINDOW_GOOD   (WINDOW_GOOD)
    ) u_lane (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .arm_i  (arm[g]),
      .rise_i (rise[g]),
      .grade_o(lane_grade[g])
    );
  end

  always_comb begin
    perfect_d = '0;
    good_d    = '0;
    miss_d    = '0;
    boo_d     = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      perfect_d[n] = (lane_grade[n] == GR_PERFECT);
      good_d[n]    = (lane_grade[n] == GR_GOOD);
      miss_d[n]    = (lane_grade[n] == GR_MISS);
      boo_d[n]     = (lane_grade[n] == GR_BOO);
    end
  end

  // A miss anywhere breaks the combo even if other lanes hit in the same cycle.
  always_comb begin
    combo_sum = {1'b0, combo_q} + 17'(popcount4(perfect_d | good_d));
    if (|miss_d) begin
      combo_d = '0;
    end else if (combo_sum[16]) begin
      combo_d = 16'hFFFF;
    end else begin
      combo_d = combo_sum[15:0];
    end
  end

  // Held-button history starts all-ones so a press spanning reset is ignored.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      btn_q     <= '1;
      perfect_q <= '0;
      good_q    <= '0;
      miss_q    <= '0;
      boo_q     <= '0;
      combo_q   <= '0;
    end else begin
      btn_q     <= bus.buttons_i;
      perfect_q <= perfect_d;
      good_q    <= good_d;
      miss_q    <= miss_d;
      boo_q     <= boo_d;
      combo_q   <= combo_d;
    end
  end

  assign bus.perfect_o = perfect_q;
  assign bus.good_o    = good_q;
  assign bus.miss_o    = miss_q;
  assign bus.boo_o     = boo_q;
  assign bus.combo_o   = combo_q;

`ifdef STEP_JUDGE_SCORE_EN
  logic [23:0] score_q, score_d;
  logic [24:0] score_sum;

  always_comb begin
    score_sum = {1'b0, score_q}
              + 25'({popcount4(perfect_d), 1'b0})
              + 25'(popcount4(good_d));
    score_d   = score_sum[24] ? 24'hFFFFFF : score_sum[23:0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign bus.score_o = score_q;
`endif

endmodule

// File: tb/tb_step_judge.sv
// tb/tb_step_judge.sv - directed and randomized checks of step_judge against a timestamp-based model
module tb_step_judge;
  import step_judge_pkg::*;

  localparam int WP = 4;
  localparam int WG = 8;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  step_judge_if bus();

  step_judge #(.WINDOW_PERFECT(WP), .WINDOW_GOOD(WG)) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a lane is either free or holds the cycle number at which it was armed.
  bit         m_armed [4];
  int         m_arm_t [4];
  int         t;
  logic [3:0] m_btn;
  logic [3:0] e_perf, e_good, e_miss, e_boo;
  int         e_combo, e_score;

  task automatic check(string tag, logic [23:0] obs, logic [23:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".perfect"}, 24'(bus.perfect_o), 24'(e_perf));
    check({tag, ".good"},    24'(bus.good_o),    24'(e_good));
    check({tag, ".miss"},    24'(bus.miss_o),    24'(e_miss));
    check({tag, ".boo"},     24'(bus.boo_o),     24'(e_boo));
    check({tag, ".combo"},   24'(bus.combo_o),   24'(e_combo));
`ifdef STEP_JUDGE_SCORE_EN
    check({tag, ".score"},   bus.score_o,        24'(e_score));
`endif
  endtask

  task automatic model_step(logic six, logic [3:0] note, logic [3:0] btn);
    logic [3:0] rise;
    logic [3:0] arm;
    int c;
    int hits;
    rise = btn & ~m_btn;
    arm  = {4{six}} & note;
    e_perf = '0; e_good = '0; e_miss = '0; e_boo = '0;
    for (int n = 0; n < 4; n++) begin
      if (m_armed[n]) begin
        c = t - m_arm_t[n] - 1;
        if (rise[n]) begin
          if (c < WP) e_perf[n] = 1'b1;
          else        e_good[n] = 1'b1;
        end else if (arm[n] || c == WG - 1) begin
          e_miss[n] = 1'b1;
        end
        if (arm[n]) m_arm_t[n] = t;
        else if (rise[n] || c == WG - 1) m_armed[n] = 1'b0;
      end else if (arm[n]) begin
        if (rise[n]) e_perf[n] = 1'b1;
        else begin
          m_armed[n] = 1'b1;
          m_arm_t[n] = t;
        end
      end else if (rise[n]) begin
        e_boo[n] = 1'b1;
      end
    end
    hits = $countones(e_perf | e_good);
    if (e_miss != 0) e_combo = 0;
    else e_combo = (e_combo + hits > 65535) ? 65535 : e_combo + hits;
    e_score = e_score + 2 * $countones(e_perf) + $countones(e_good);
    if (e_score > 24'hFFFFFF) e_score = 24'hFFFFFF;
    m_btn = btn;
    t++;
  endtask

  task automatic cycle(logic six, logic [3:0] note, logic [3:0] btn, string tag);
    bus.sixteenth_i = six;
    bus.note_i      = note;
    bus.buttons_i   = btn;
    model_step(six, note, btn);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(logic [3:0] btn);
    reset_i         = 1'b1;
    bus.sixteenth_i = 1'b0;
    bus.note_i      = '0;
    bus.buttons_i   = btn;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    for (int n = 0; n < 4; n++) m_armed[n] = 1'b0;
    m_btn = 4'hF;
    e_perf = '0; e_good = '0; e_miss = '0; e_boo = '0;
    e_combo = 0;
    e_score = 0;
    t++;
    check_all("reset");
  endtask

  initial begin
    logic [3:0] btn;
    logic [3:0] flip;
    int score_before;
    t = 0;
    bus.sixteenth_i = 1'b0;
    bus.note_i      = '0;
    bus.buttons_i   = '0;
    @(posedge clk);
    #1;
    do_reset(4'h0);

    // Lane 0 press at c=2 grades PERFECT.
    cycle(1'b1, 4'b0001, 4'b0000, "arm0");
    cycle(1'b0, 4'b0000, 4'b0000, "l0_c0");
    cycle(1'b0, 4'b0000, 4'b0000, "l0_c1");
    cycle(1'b0, 4'b0000, 4'b0001, "l0_press");
    check("perfect_lane0", 24'(bus.perfect_o), 24'h1);
    check("combo_after_perfect", 24'(bus.combo_o), 24'd1);
    cycle(1'b0, 4'b0000, 4'b0000, "l0_release");

    // Lane 2 press at c=6 grades GOOD.
    cycle(1'b1, 4'b0100, 4'b0000, "arm2");
    for (int i = 0; i < 6; i++) cycle(1'b0, 4'b0000, 4'b0000, "l2_wait");
    cycle(1'b0, 4'b0000, 4'b0100, "l2_press");
    check("good_lane2", 24'(bus.good_o), 24'h4);
    check("combo_after_good", 24'(bus.combo_o), 24'd2);
    cycle(1'b0, 4'b0000, 4'b0000, "l2_release");

    // Lane 3 never pressed: MISS after c=7, combo cleared.
    cycle(1'b1, 4'b1000, 4'b0000, "arm3");
    for (int i = 0; i < 8; i++) cycle(1'b0, 4'b0000, 4'b0000, "l3_wait");
    check("miss_lane3", 24'(bus.miss_o), 24'h8);
    check("combo_after_miss", 24'(bus.combo_o), 24'd0);
    cycle(1'b0, 4'b0000, 4'b0000, "l3_after");
    check("miss_one_cycle", 24'(bus.miss_o), 24'h0);

    // Lanes 0+1 both PERFECT at c=1.
    score_before = e_score;
    cycle(1'b1, 4'b0011, 4'b0000, "arm01");
    cycle(1'b0, 4'b0000, 4'b0000, "l01_c0");
    cycle(1'b0, 4'b0000, 4'b0011, "l01_press");
    check("perfect_lanes01", 24'(bus.perfect_o), 24'h3);
    check("combo_plus2", 24'(bus.combo_o), 24'd2);
`ifdef STEP_JUDGE_SCORE_EN
    check("score_plus4", bus.score_o, 24'(score_before + 4));
`endif
    cycle(1'b0, 4'b0000, 4'b0000, "l01_release");

    // Press on idle lane 1 is a BOO and leaves combo alone.
    cycle(1'b0, 4'b0000, 4'b0010, "boo1");
    check("boo_lane1", 24'(bus.boo_o), 24'h2);
    check("combo_kept_on_boo", 24'(bus.combo_o), 24'd2);
    cycle(1'b0, 4'b0000, 4'b0000, "boo_release");

    // Buttons held through reset release produce no press.
    cycle(1'b0, 4'b0000, 4'b1111, "hold_pre");
    do_reset(4'hF);
    cycle(1'b0, 4'b0000, 4'b1111, "hold_post");
    check("no_boo_after_reset", 24'(bus.boo_o), 24'h0);
    cycle(1'b0, 4'b0000, 4'b0000, "hold_release");

    // Re-arm at c=5 misses the old note and opens a new window; reset at c=3 kills it.
    cycle(1'b1, 4'b0001, 4'b0000, "rearm_first");
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'b0000, 4'b0000, "rearm_wait");
    cycle(1'b1, 4'b0001, 4'b0000, "rearm_second");
    check("miss_on_rearm", 24'(bus.miss_o), 24'h1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0000, 4'b0000, "rearm_new");
    do_reset(4'h0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 4'b0000, 4'b0000, "post_reset_idle");
    check("no_late_miss", 24'(bus.miss_o), 24'h0);

    // Randomized traffic.
    btn = 4'h0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        btn = 4'($urandom);
        do_reset(btn);
      end else begin
        flip = '0;
        for (int n = 0; n < 4; n++) flip[n] = ($urandom_range(0, 5) == 0);
        btn = btn ^ flip;
        cycle($urandom_range(0, 5) == 0, 4'($urandom), btn, "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
